// File: rtl/wl_sweep_scheduler_pkg.sv
// Shared types and widths for the word-length sweep scheduler.
package wl_sweep_scheduler_pkg;
  localparam int FRAC_W   = 8;
  localparam int MSE_W    = 64;
  localparam int CNT_W    = 16;
  localparam int MAX_CHAN = 16;

  typedef enum logic [3:0] {
    S_IDLE, S_APPLY, S_RST, S_SETTLE, S_START, S_WAIT, S_JUDGE, S_NEXT_CH, S_DONE
  } sweep_state_t;

  // Byte idx of a packed per-channel width vector (ch0 in the LSB byte).
  function automatic logic [FRAC_W-1:0] frac_max_of(input logic [MAX_CHAN*FRAC_W-1:0] fm,
                                                    input int idx);
    return fm[idx*FRAC_W +: FRAC_W];
  endfunction
endpackage

// File: rtl/wl_sweep_scheduler_if.sv
// Control/result bundle between the sweep scheduler and the control unit / collector.
interface wl_sweep_scheduler_if #(parameter int NUM_CHAN = 3);
  import wl_sweep_scheduler_pkg::*;
  logic                 go;
  logic [MSE_W-1:0]     mse_limit;
  logic [MSE_W-1:0]     mse_data;
  logic                 mse_valid;
  logic [FRAC_W-1:0]    sw_frac [NUM_CHAN];
  logic                 soft_rstn;
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 timeout_err;
  logic [CNT_W-1:0]     eval_count;

  modport master (input go, mse_limit, mse_data, mse_valid,
                  output sw_frac, soft_rstn, start, busy, done, timeout_err, eval_count);
  modport slave  (output go, mse_limit, mse_data, mse_valid,
                  input sw_frac, soft_rstn, start, busy, done, timeout_err, eval_count);
endinterface

// File: rtl/wl_sweep_scheduler_cycle_timer.sv
// Loadable down-counter; expired is high while the count sits at zero.
module wl_sweep_scheduler_cycle_timer #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expired
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - W'(1);
  end

  assign expired = (cnt == '0);
endmodule

// File: rtl/wl_sweep_scheduler.sv
// Word-length sweep: per channel, narrows sw_frac until the MSE exceeds the limit.
// state     | meaning
// IDLE      | waiting for go
// APPLY     | write candidate width into sw_frac[ch]
// RST       | datapath soft reset held low
// SETTLE    | pipeline fill after reset release
// START     | one-cycle start pulse to the collector
// WAIT      | waiting for mse_valid or timeout
// JUDGE     | compare captured MSE with limit
// NEXT_CH   | advance to next channel (skips channels with no room)
// DONE      | sweep finished, results held
module wl_sweep_scheduler
  import wl_sweep_scheduler_pkg::*;
#(
  parameter int                         NUM_CHAN    = 3,
  parameter logic [NUM_CHAN*FRAC_W-1:0] FRAC_MAX    = {8'd24, 8'd12, 8'd12},
  parameter logic [FRAC_W-1:0]          FRAC_MIN    = 8'd0,
  parameter int                         RST_CYC     = 4,
  parameter int                         SETTLE_CYC  = 16,
  parameter int                         TIMEOUT_CYC = 2**24
) (
  input logic                 clk,
  input logic                 rst,
  wl_sweep_scheduler_if.master bus
);
  localparam int CH_W = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CHAN - 1);
  localparam logic [MAX_CHAN*FRAC_W-1:0] FM_EXT =
    {{((MAX_CHAN - NUM_CHAN) * FRAC_W){1'b0}}, FRAC_MAX};
  localparam int TMAX = (TIMEOUT_CYC > SETTLE_CYC)
    ? ((TIMEOUT_CYC > RST_CYC) ? TIMEOUT_CYC : RST_CYC)
    : ((SETTLE_CYC > RST_CYC) ? SETTLE_CYC : RST_CYC);
  localparam int TW = (TMAX > 2) ? $clog2(TMAX) : 1;

  sweep_state_t      state, state_nxt;
  logic [CH_W-1:0]   ch;
  logic [FRAC_W-1:0] cand;
  logic [FRAC_W-1:0] best   [NUM_CHAN];
  logic [FRAC_W-1:0] frac_q [NUM_CHAN];
  logic [MSE_W-1:0]  mse_q;
  logic              t_load, t_exp, pass;
  logic [TW-1:0]     t_val;
  logic [FRAC_W-1:0] fm_first, fm_next;

  assign fm_first    = frac_max_of(FM_EXT, 0);
  assign fm_next     = frac_max_of(FM_EXT, int'(ch) + 1);
  assign pass        = (mse_q <= bus.mse_limit);
  assign bus.sw_frac = frac_q;

  wl_sweep_scheduler_cycle_timer #(.W(TW)) u_timer (
    .clk(clk), .rst(rst), .load(t_load), .load_val(t_val), .expired(t_exp)
  );

  // The timer is loaded on entry to each timed phase, so each phase lasts exactly N cycles.
  always_comb begin
    state_nxt = state;
    t_load    = 1'b0;
    t_val     = '0;
    case (state)
      S_IDLE, S_DONE: if (bus.go) state_nxt = (fm_first <= FRAC_MIN) ? S_NEXT_CH : S_APPLY;
      S_APPLY: begin
        state_nxt = S_RST;
        t_load    = 1'b1;
        t_val     = TW'(RST_CYC - 1);
      end
      S_RST: if (t_exp) begin
        state_nxt = S_SETTLE;
        t_load    = 1'b1;
        t_val     = TW'(SETTLE_CYC - 1);
      end
      S_SETTLE: if (t_exp) begin
        state_nxt = S_START;
        t_load    = 1'b1;
        t_val     = TW'(TIMEOUT_CYC - 1);
      end
      S_START: state_nxt = S_WAIT;
      S_WAIT: begin
        if (bus.mse_valid) state_nxt = S_JUDGE;
        else if (t_exp)    state_nxt = S_DONE;
      end
      S_JUDGE:   state_nxt = (pass && cand != FRAC_MIN) ? S_APPLY : S_NEXT_CH;
      S_NEXT_CH: begin
        if (ch == LAST_CH)          state_nxt = S_DONE;
        else if (fm_next > FRAC_MIN) state_nxt = S_APPLY;
      end
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      ch              <= '0;
      cand            <= '0;
      mse_q           <= '0;
      bus.soft_rstn   <= 1'b1;
      bus.start       <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.timeout_err <= 1'b0;
      bus.eval_count  <= '0;
      for (int i = 0; i < NUM_CHAN; i++) begin
        best[i]   <= frac_max_of(FM_EXT, i);
        frac_q[i] <= frac_max_of(FM_EXT, i);
      end
    end else begin
      state           <= state_nxt;
      bus.soft_rstn   <= (state_nxt != S_RST);
      bus.start       <= (state_nxt == S_START);
      bus.busy        <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
      bus.done        <= (state_nxt == S_DONE);
      case (state)
        S_IDLE, S_DONE: if (bus.go) begin
          ch              <= '0;
          cand            <= fm_first - 8'd1;
          bus.timeout_err <= 1'b0;
          bus.eval_count  <= '0;
          for (int i = 0; i < NUM_CHAN; i++) begin
            best[i]   <= frac_max_of(FM_EXT, i);
            frac_q[i] <= frac_max_of(FM_EXT, i);
          end
        end
        S_APPLY: frac_q[ch] <= cand;
        S_WAIT: begin
          if (bus.mse_valid) begin
            mse_q <= bus.mse_data;
            if (bus.eval_count != '1) bus.eval_count <= bus.eval_count + 1'b1;
          end else if (t_exp) begin
            frac_q[ch]      <= best[ch];
            bus.timeout_err <= 1'b1;
          end
        end
        S_JUDGE: begin
          if (pass) begin
            best[ch] <= cand;
            if (cand != FRAC_MIN) cand <= cand - 8'd1;
          end else begin
            frac_q[ch] <= best[ch];
          end
        end
        S_NEXT_CH: if (ch != LAST_CH) begin
          ch   <= ch + 1'b1;
          cand <= fm_next - 8'd1;
        end
        default: ;
      endcase
    end
  end
endmodule
